// File: rtl/ascon_permutation_ctrl_if.sv
// ASCON permutation request/response bundle between the mode FSM and the sequencer.
// latency: n/a (wires only)
// backpressure: none; start_i is taken whenever the sequencer is IDLE or DONE.
//
// Signals (directions as seen by the sequencer, i.e. the slave modport):
//   start_i  in  : start request, pulse or level
//   mode_i   in  : 0 = pa (12 rounds), 1 = pb (NB_ROUNDS_B rounds)
//   state_i  in  : 320-bit permutation input {x0, x1, x2, x3, x4}, x0 in the top word
//   state_o  out : permutation state register
//   busy_o   out : rounds remain to be applied
//   done_o   out : one-cycle pulse, state_o holds the final result
//   round_o  out : index of the next round to be applied
interface ascon_permutation_ctrl_if;
    logic         start_i;
    logic         mode_i;
    logic [319:0] state_i;
    logic [319:0] state_o;
    logic         busy_o;
    logic         done_o;
    logic [3:0]   round_o;

    // mode FSM side
    modport master (
        output start_i,
        output mode_i,
        output state_i,
        input  state_o,
        input  busy_o,
        input  done_o,
        input  round_o
    );

    // permutation sequencer side
    modport slave (
        input  start_i,
        input  mode_i,
        input  state_i,
        output state_o,
        output busy_o,
        output done_o,
        output round_o
    );
endinterface

// File: rtl/ascon_permutation_ctrl.sv
// ASCON permutation sequencer: iterates constant-add / S-box / linear layer over a 320-bit state.
// latency: N cycles from start to done (N = 12 for pa, NB_ROUNDS_B for pb), N/2 with ASCON_UNROLL2_EN.
// backpressure: none; start_i is accepted in IDLE and in the DONE cycle, ignored while busy.
//
// Ports:
//   clock_i   : system clock, rising edge
//   resetb_i  : asynchronous active-low reset
//   bus       : ascon_permutation_ctrl_if.slave (start/mode/state in, state/busy/done/round out)
//
// Parameters:
//   NB_ROUNDS_B : pb round count, 6 or 8 (pa is always 12)
//
// Build option:
//   ASCON_UNROLL2_EN : when defined, two chained rounds are applied per clock (counter step 2).
//                      Final state is bit-identical to the one-round-per-clock build.
module ascon_permutation_ctrl #(
    parameter int unsigned NB_ROUNDS_B = 6
) (
    input  logic                           clock_i,
    input  logic                           resetb_i,
    ascon_permutation_ctrl_if.slave        bus
);

    typedef logic [319:0] type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // First round index of pb; pa always starts at 0. Both sequences end at round 11.
    localparam logic [3:0] R0_B      = 4'(12 - NB_ROUNDS_B);
    localparam logic [3:0] ROUND_END = 4'd12;

`ifdef ASCON_UNROLL2_EN
    localparam logic [3:0] STEP = 4'd2;
`else
    localparam logic [3:0] STEP = 4'd1;
`endif

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------

    // Round constant {0xF - r, r} lands in the low byte of x2 (bits 135:128).
    function automatic type_state add_const(input type_state s, input logic [3:0] r);
        type_state o;
        o           = s;
        o[135:128]  = s[135:128] ^ {4'hF - r, r};
        return o;
    endfunction

    // Bitsliced 5-bit S-box applied to all 64 columns at once (x0 is the column MSB).
    function automatic type_state sbox_layer(input type_state s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;

        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;

        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;

        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        return {x0, x1, x2, x3, x4};
    endfunction

    // Per-word linear diffusion: x ^= ror(x, a) ^ ror(x, b).
    // Rotations are written as bit-slice concatenations: ror(x, n) = {x[n-1:0], x[63:n]}.
    function automatic type_state diffusion_lin(input type_state s);
        logic [63:0] x0, x1, x2, x3, x4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];

        x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
        x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
        x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
        x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
        x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};

        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
        return diffusion_lin(sbox_layer(add_const(s, r)));
    endfunction

    // ------------------------------------------------------------------
    // State, counter and FSM registers
    // ------------------------------------------------------------------
    type_state  state_q;
    logic [3:0] cnt_q;
    fsm_t       fsm_q;
    logic       busy_q;
    logic       done_q;

    // ------------------------------------------------------------------
    // Next-round selection
    // In IDLE/DONE the round is applied to the incoming state (a start may be
    // taken there); in RUN it is applied to the register. Outside RUN the
    // result is only committed when start_i is high.
    // ------------------------------------------------------------------
    type_state  round_src;
    logic [3:0] round_idx;
    logic [3:0] start_r0;
    logic [3:0] cnt_nxt;
    type_state  round_out;

    assign start_r0 = bus.mode_i ? R0_B : 4'd0;

    always_comb begin
        round_src = state_q;
        round_idx = cnt_q;
        if (fsm_q != RUN) begin
            round_src = bus.state_i;
            round_idx = start_r0;
        end
    end

    assign cnt_nxt = round_idx + STEP;

`ifdef ASCON_UNROLL2_EN
    // Two rounds chained in one cycle: c_r then c_r+1. N is always even so
    // the pair never straddles the end of the sequence.
    type_state round_mid;
    assign round_mid = ascon_round(round_src, round_idx);
    assign round_out = ascon_round(round_mid, round_idx + 4'd1);
`else
    assign round_out = ascon_round(round_src, round_idx);
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM. busy/done are registered so start_i never reaches them
    // combinationally.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        state_q <= round_out;
                        cnt_q   <= cnt_nxt;
                        if (cnt_nxt == ROUND_END) begin
                            fsm_q  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            fsm_q  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end else begin
                        // state_q and cnt_q hold so the mode FSM can read the result
                        fsm_q  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    cnt_q   <= cnt_nxt;
                    if (cnt_nxt == ROUND_END) begin
                        fsm_q  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state_o = state_q;
    assign bus.round_o = cnt_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// Self-checking bench for ascon_permutation_ctrl against a table-driven ASCON permutation model.
// latency: n/a
// backpressure: n/a
module tb_ascon_permutation_ctrl;

    localparam int NB_B = 6;
`ifdef ASCON_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    // ASCON 5-bit S-box, input index {x0,x1,x2,x3,x4} with x0 as MSB.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    int checks = 0;
    int errors = 0;

    ascon_permutation_ctrl_if bus_if ();

    ascon_permutation_ctrl #(
        .NB_ROUNDS_B (NB_B)
    ) dut (
        .clock_i  (clk),
        .resetb_i (rstn),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  sb;
        logic [319:0] o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = 12 - n; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ 8'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                sb  = SBOX[col];
                for (int i = 0; i < 5; i++) y[i][b] = sb[4 - i];
            end
            for (int i = 0; i < 5; i++)
                x[i] = y[i] ^ ror64(y[i], ROT_A[i]) ^ ror64(y[i], ROT_B[i]);
        end
        for (int i = 0; i < 5; i++) o[319 - 64*i -: 64] = x[i];
        return o;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) v = {v[287:0], 32'($urandom)};
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one permutation at the current negedge and follow it to done_o.
    // hold=1 keeps start_i high throughout (level-start operation).
    task automatic do_perm(input logic mode, input logic [319:0] s_in, input bit hold,
                           output logic [319:0] res);
        int n, r0, lat, cyc;
        bit seen;
        logic [319:0] exp;
        n   = mode ? NB_B : 12;
        r0  = 12 - n;
        lat = n / STEP;
        exp = model_perm(s_in, n);
        bus_if.start_i = 1'b1;
        bus_if.mode_i  = mode;
        bus_if.state_i = s_in;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_if.done_o) begin
                seen = 1'b1;
                chk("latency", 320'(cyc), 320'(lat));
                chk("result", bus_if.state_o, exp);
                chk("round_at_done", 320'(bus_if.round_o), 320'd12);
                chk("busy_at_done", 320'(bus_if.busy_o), 320'd0);
            end else begin
                chk("busy_run", 320'(bus_if.busy_o), 320'd1);
                chk("round_run", 320'(bus_if.round_o), 320'(r0 + cyc * STEP));
                // Inputs change freely while running: none of it may be resampled.
                if (!hold) bus_if.start_i = 1'($urandom_range(0, 1));
                bus_if.mode_i  = 1'($urandom_range(0, 1));
                bus_if.state_i = rand320();
            end
        end
        chk("done_seen", 320'(seen), 320'd1);
        res = exp;
    endtask

    task automatic idle(input int k, input logic [319:0] held);
        bus_if.start_i = 1'b0;
        repeat (k) begin
            @(negedge clk);
            chk("idle_busy", 320'(bus_if.busy_o), 320'd0);
            chk("idle_done", 320'(bus_if.done_o), 320'd0);
            chk("idle_round", 320'(bus_if.round_o), 320'd12);
            chk("idle_state", bus_if.state_o, held);
            bus_if.state_i = rand320();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [319:0] res, res2, vec;

        // Reset with random inputs toggling
        bus_if.start_i = 1'b0;
        bus_if.mode_i  = 1'b0;
        bus_if.state_i = '0;
        #1 rstn = 1'b0;
        repeat (3) begin
            bus_if.start_i = 1'($urandom_range(0, 1));
            bus_if.mode_i  = 1'($urandom_range(0, 1));
            bus_if.state_i = rand320();
            @(negedge clk);
            chk("rst_state", bus_if.state_o, 320'd0);
            chk("rst_round", 320'(bus_if.round_o), 320'd0);
            chk("rst_busy", 320'(bus_if.busy_o), 320'd0);
            chk("rst_done", 320'(bus_if.done_o), 320'd0);
        end
        bus_if.start_i = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 320'(bus_if.done_o), 320'd0);

        // pa on the all-zero state
        do_perm(1'b0, 320'd0, 1'b0, res);
        idle(2, res);

        // pb on the reference vector (first round index 6, constant 8'h96)
        vec = {64'h1642cee0845634e5, 64'h17397d1b2a296525, 64'h49dbe29ab8516baf,
               64'h110e5ecc42a8a463, 64'hb16f79e94eb17171};
        do_perm(1'b1, vec, 1'b0, res);
        idle(1, res);

        // Back-to-back: new start in the DONE cycle, new input XORed onto the result
        do_perm(1'b1, rand320(), 1'b0, res);
        do_perm(1'b0, res ^ rand320(), 1'b0, res2);
        do_perm(1'b1, res2 ^ rand320(), 1'b0, res);
        idle(1, res);

        // Random modes and states
        for (int i = 0; i < 4; i++) begin
            do_perm(1'($urandom_range(0, 1)), rand320(), 1'b0, res);
            idle(1 + int'($urandom_range(0, 2)), res);
        end

        // Reset in the middle of a pa run
        bus_if.start_i = 1'b1;
        bus_if.mode_i  = 1'b0;
        bus_if.state_i = rand320();
        @(negedge clk);
        bus_if.start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_round", 320'(bus_if.round_o), 320'(5 * STEP > 11 ? 12 : 5 * STEP));
        #2 rstn = 1'b0;
        #1;
        chk("abort_state", bus_if.state_o, 320'd0);
        chk("abort_round", 320'(bus_if.round_o), 320'd0);
        chk("abort_busy", 320'(bus_if.busy_o), 320'd0);
        chk("abort_done", 320'(bus_if.done_o), 320'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", 320'(bus_if.done_o), 320'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("after_abort_done", 320'(bus_if.done_o), 320'd0);
        do_perm(1'b0, rand320(), 1'b0, res);
        idle(1, res);

        // start_i held high: periodic done, each result fed back as the next input
        do_perm(1'b0, rand320(), 1'b1, res);
        do_perm(1'b0, res, 1'b1, res2);
        do_perm(1'b1, res2, 1'b1, res);
        do_perm(1'b1, res, 1'b1, res2);
        idle(2, res2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
